// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word/opcode types, halt opcode, fetch FSM states.
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [4:0]        regbits_t;
  typedef logic [5:0]        opcode_t;

  localparam opcode_t OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SKID = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input opcode_t op);
    return op == OP_HALT;
  endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, npc} holding register for an icache hit that arrives while decode stalls.
module fetch_skid_buf #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din_instr,
  input  logic [W-1:0] din_npc,
  output logic         full,
  output logic [W-1:0] instr,
  output logic [W-1:0] npc
);
  // clear wins over load so a redirect never leaves stale data behind
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      full  <= 1'b0;
      instr <= '0;
      npc   <= '0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= din_instr;
      npc   <= din_npc;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, RUN/SKID/HALT sequencer and IF/ID latch.
//  state | meaning
//  RUN   | fetching, iREN=1
//  SKID  | skid holds a hit, decode still stalled, PC held
//  HALT  | halt opcode latched, PC held, halted=1
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] instru,
  output logic [WORD_W-1:0] nPC,
  output logic              valid,
  output logic              halted
);
  fetch_state_t      state, state_n;
  logic [WORD_W-1:0] pc, pc_n, pc_plus4;
  logic [WORD_W-1:0] instru_n, npc_n;
  logic              valid_n;
  logic              skid_load, skid_clear, skid_full;
  logic [WORD_W-1:0] skid_instr, skid_npc;

  assign pc_plus4 = pc + WORD_W'(4);
  assign imemaddr = pc;
  assign iREN     = (state == RUN);
  assign halted   = (state == HALT);

  fetch_skid_buf #(.W(WORD_W)) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .load      (skid_load),
    .clear     (skid_clear),
    .din_instr (imemload),
    .din_npc   (pc_plus4),
    .full      (skid_full),
    .instr     (skid_instr),
    .npc       (skid_npc)
  );

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instru_n   = instru;
    npc_n      = nPC;
    valid_n    = valid;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (redirect) begin
      pc_n       = redirect_pc;
      instru_n   = '0;
      npc_n      = '0;
      valid_n    = 1'b0;
      skid_clear = 1'b1;
      state_n    = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (stall) begin
            if (ihit) begin
              skid_load = 1'b1;
              pc_n      = pc_plus4;
              state_n   = SKID;
            end
          end else if (ihit) begin
            instru_n = imemload;
            npc_n    = pc_plus4;
            valid_n  = 1'b1;
            pc_n     = pc_plus4;
            if (is_halt(imemload[31:26])) state_n = HALT;
          end else begin
            valid_n = 1'b0;
          end
        end
        SKID: begin
          if (!stall && skid_full) begin
            instru_n   = skid_instr;
            npc_n      = skid_npc;
            valid_n    = 1'b1;
            skid_clear = 1'b1;
            state_n    = is_halt(skid_instr[31:26]) ? HALT : RUN;
          end
        end
        HALT: begin
          if (!stall) valid_n = 1'b0;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      pc     <= WORD_W'(PC_INIT);
      instru <= '0;
      nPC    <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      instru <= instru_n;
      nPC    <= npc_n;
      valid  <= valid_n;
    end
  end
endmodule
